// File: rtl/matinv_stream_ctrl.sv
// Stream-side initiator for the matinv<N> inverter core.
// Packs an input element stream into the inverter's flat matrix bus and runs
// one inversion. It then streams the inverse, or a single singular marker, out
// on a valid/ready interface. A watchdog bounds the time spent waiting on the
// inverter.
module matinv_stream_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int MATRIX_SIZE    = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        s_valid,
  output logic                                        s_ready,
  input  logic [DATA_WIDTH-1:0]                       s_data,
  output logic                                        m_valid,
  input  logic                                        m_ready,
  output logic [DATA_WIDTH-1:0]                       m_data,
  output logic                                        m_last,
  output logic                                        m_singular,
  output logic                                        inv_rst,
  input  logic                                        inv_ready,
  input  logic                                        inv_complete,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] inv_matrix,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] inv_result,
  input  logic                                        inv_singular,
  output logic                                        busy,
  output logic                                        err_timeout
);

  localparam int NE    = MATRIX_SIZE * MATRIX_SIZE;
  localparam int CNT_W = (NE > 1) ? $clog2(NE) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NE - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {LOAD, WAIT_RDY, RUN, DRAIN} state_t;

  state_t                       state;
  logic [CNT_W-1:0]             in_cnt;
  logic [CNT_W-1:0]             out_cnt;
  logic [CNT_W-1:0]             nxt_cnt;
  logic [WD_W-1:0]              wd_cnt;
  logic                         run_armed;
  logic                         sing_r;
  logic [NE*DATA_WIDTH-1:0]     res_buf;
  logic                         take_result;
  logic                         wd_hit;

  // Select the element for an output beat; a singular result carries zero data.
  function automatic logic [DATA_WIDTH-1:0] pick_elem(
    input logic [NE*DATA_WIDTH-1:0] bus_v,
    input logic [CNT_W-1:0]         idx,
    input logic                     sing
  );
    if (sing) pick_elem = '0;
    else      pick_elem = bus_v[idx*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign s_ready = (state == LOAD);
  assign nxt_cnt = out_cnt + 1'b1;

  // The first RUN cycle ignores inv_complete so a completion left over from the
  // previous inversion cannot be mistaken for this one.
  assign take_result = (state == RUN) && run_armed && inv_complete;
  // Complete has priority over the watchdog when both land in the same cycle.
  assign wd_hit = (TIMEOUT_CYCLES != 0) && (state == RUN) && (wd_cnt == WD_LAST);

  // Result buffer: plain data capture at completion, no reset needed.
  always_ff @(posedge clk) begin
    if (take_result) res_buf <= inv_result;
  end

  // Main sequencer: load, wait for inverter ready, run with watchdog, drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= LOAD;
      in_cnt      <= '0;
      out_cnt     <= '0;
      wd_cnt      <= '0;
      run_armed   <= 1'b0;
      sing_r      <= 1'b0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_singular  <= 1'b0;
      m_data      <= '0;
      inv_rst     <= 1'b1;
      inv_matrix  <= '0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (s_valid) begin
            inv_matrix[in_cnt*DATA_WIDTH +: DATA_WIDTH] <= s_data;
            if (in_cnt == LAST_IDX) begin
              in_cnt <= '0;
              state  <= WAIT_RDY;
              busy   <= 1'b1;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        WAIT_RDY: begin
          if (inv_ready) begin
            inv_rst   <= 1'b0;
            wd_cnt    <= '0;
            run_armed <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          run_armed <= 1'b1;
          if (take_result) begin
            sing_r  <= inv_singular;
            inv_rst <= 1'b1;
            out_cnt <= '0;
            state   <= DRAIN;
          end else if (wd_hit) begin
            err_timeout <= 1'b1;
            sing_r      <= 1'b1;
            inv_rst     <= 1'b1;
            out_cnt     <= '0;
            state       <= DRAIN;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!m_valid) begin
            m_valid    <= 1'b1;
            m_data     <= pick_elem(res_buf, out_cnt, sing_r);
            m_last     <= sing_r || (out_cnt == LAST_IDX);
            m_singular <= sing_r;
          end else if (m_ready) begin
            if (m_last) begin
              m_valid    <= 1'b0;
              m_last     <= 1'b0;
              m_singular <= 1'b0;
              out_cnt    <= '0;
              busy       <= 1'b0;
              state      <= LOAD;
            end else begin
              out_cnt <= nxt_cnt;
              m_data  <= pick_elem(res_buf, nxt_cnt, sing_r);
              m_last  <= (nxt_cnt == LAST_IDX);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_matinv_stream_ctrl.sv
// Randomized bench for matinv_stream_ctrl (2x2, 16-bit, watchdog of 20 cycles).
// The bench plays the inverter and both stream endpoints, and predicts outputs
// from per-transaction expectations kept in queues.
module tb_matinv_stream_ctrl;

  localparam int DW = 16;
  localparam int N  = 2;
  localparam int NE = N * N;
  localparam int TO = 20;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic [DW-1:0]      s_data;
  logic               m_valid;
  logic               m_ready;
  logic [DW-1:0]      m_data;
  logic               m_last;
  logic               m_singular;
  logic               inv_rst;
  logic               inv_ready;
  logic               inv_complete;
  logic [NE*DW-1:0]   inv_matrix;
  logic [NE*DW-1:0]   inv_result;
  logic               inv_singular;
  logic               busy;
  logic               err_timeout;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_err  = 1'b0;

  matinv_stream_ctrl #(
    .DATA_WIDTH    (DW),
    .MATRIX_SIZE   (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_singular  (m_singular),
    .inv_rst     (inv_rst),
    .inv_ready   (inv_ready),
    .inv_complete(inv_complete),
    .inv_matrix  (inv_matrix),
    .inv_result  (inv_result),
    .inv_singular(inv_singular),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // mode: 0 normal, 1 singular, 2 never completes, 3 reset while running.
  // bp:   0 m_ready always 1, 1 toggles 1,0,1,0, 2 random.
  task automatic run_txn(input logic [NE*DW-1:0] mat_p, input logic [NE*DW-1:0] res_p,
                         input int mode, input int gap, input int bp, input bit stale);
    logic [DW-1:0] exp_d[$];
    bit            exp_l[$];
    bit            exp_s[$];
    logic [DW-1:0] pd;
    logic          pl, ps;
    bit            prev_stall;
    bit            tog;
    int            cnt;
    int            lat;

    // Load phase, with optional idle cycles before each element.
    for (int i = 0; i < NE; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = DW'($urandom);
        check("load_gap_busy", busy, 0);
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = mat_p[i*DW +: DW];
      check("load_s_ready", s_ready, 1);
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = DW'($urandom);
    check("wait_rdy_busy", busy, 1);
    check("wait_rdy_s_ready", s_ready, 0);
    check("inv_matrix", inv_matrix, mat_p);
    check("inv_rst_held", inv_rst, 1);

    // Inverter becomes ready after a random delay.
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      check("inv_rst_wait", inv_rst, 1);
    end
    @(negedge clk);
    inv_ready = 1'b1;
    @(negedge clk);
    inv_ready = 1'b0;
    check("inv_rst_fall", inv_rst, 0);

    if (mode == 3) begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      exp_err = 1'b0;
      check("rst_inv_rst", inv_rst, 1);
      check("rst_m_valid", m_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_s_ready", s_ready, 1);
      check("rst_inv_matrix", inv_matrix, 0);
      check("rst_err", err_timeout, 0);
      return;
    end

    // Optional stale completion in the first RUN cycle; it must be ignored.
    if (stale) begin
      inv_complete = 1'b1;
      inv_singular = 1'b1;
      inv_result   = ~res_p;
    end

    if (mode == 2) begin
      cnt = 1;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        inv_complete = 1'b0;
        inv_singular = 1'b0;
        if (inv_rst) break;
        cnt++;
      end
      exp_err = 1'b1;
      check("wd_run_cycles", cnt, TO);
      check("wd_err", err_timeout, 1);
      check("wd_inv_rst", inv_rst, 1);
    end else begin
      lat = $urandom_range(1, 12);
      repeat (lat) begin
        @(negedge clk);
        inv_complete = 1'b0;
        inv_singular = 1'b0;
        inv_result   = {$urandom, $urandom};
      end
      inv_complete = 1'b1;
      inv_result   = res_p;
      inv_singular = (mode == 1);
      @(negedge clk);
      inv_complete = 1'b0;
      inv_singular = 1'b0;
      inv_result   = {$urandom, $urandom};
      check("done_inv_rst", inv_rst, 1);
    end
    check("drain_entry_m_valid", m_valid, 0);

    // Expected output beats.
    if (mode == 0) begin
      for (int i = 0; i < NE; i++) begin
        exp_d.push_back(res_p[i*DW +: DW]);
        exp_l.push_back(i == NE - 1);
        exp_s.push_back(1'b0);
      end
    end else begin
      exp_d.push_back('0);
      exp_l.push_back(1'b1);
      exp_s.push_back(1'b1);
    end

    prev_stall = 1'b0;
    tog = 1'b1;
    pd = '0;
    pl = 1'b0;
    ps = 1'b0;
    for (int c = 0; c < 60 && exp_d.size() > 0; c++) begin
      @(negedge clk);
      if (c == 0) check("first_beat_latency", m_valid, 1);
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, pd);
        check("stall_last", m_last, pl);
        check("stall_singular", m_singular, ps);
      end
      case (bp)
        0:       m_ready = 1'b1;
        1:       begin m_ready = tog; tog = ~tog; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (m_valid && m_ready) begin
        check("beat_data", m_data, exp_d.pop_front());
        check("beat_last", m_last, exp_l.pop_front());
        check("beat_singular", m_singular, exp_s.pop_front());
        prev_stall = 1'b0;
      end else begin
        prev_stall = m_valid;
      end
      pd = m_data;
      pl = m_last;
      ps = m_singular;
    end
    check("beats_outstanding", exp_d.size(), 0);
    @(negedge clk);
    m_ready = 1'($urandom_range(0, 1));
    check("no_extra_beat", m_valid, 0);
    check("back_to_load_s_ready", s_ready, 1);
    check("back_to_load_busy", busy, 0);
    check("err_timeout_sticky", err_timeout, exp_err);
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [NE*DW-1:0] m, r;
    rst          = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    m_ready      = 1'b0;
    inv_ready    = 1'b0;
    inv_complete = 1'b0;
    inv_result   = '0;
    inv_singular = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("reset_s_ready", s_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_last", m_last, 0);
    check("reset_m_singular", m_singular, 0);
    check("reset_m_data", m_data, 0);
    check("reset_inv_rst", inv_rst, 1);
    check("reset_inv_matrix", inv_matrix, 0);
    check("reset_err", err_timeout, 0);

    // Identity: element 0 sits in the LSBs.
    m = 64'h0100_0000_0000_0100;
    run_txn(m, m, 0, 0, 0, 1'b0);
    // Singular result.
    run_txn({$urandom, $urandom}, {$urandom, $urandom}, 1, 0, 0, 1'b0);
    // Backpressure with result 1,2,3,4.
    run_txn({$urandom, $urandom}, 64'h0004_0003_0002_0001, 0, 0, 1, 1'b0);
    // Input valid only every third cycle.
    run_txn({$urandom, $urandom}, {$urandom, $urandom}, 0, 2, 0, 1'b0);
    // Random mix, including stale completions in the first RUN cycle.
    for (int t = 0; t < 10; t++) begin
      m = {$urandom, $urandom};
      r = {$urandom, $urandom};
      run_txn(m, r, $urandom_range(0, 1), $urandom_range(0, 2), 2, 1'($urandom_range(0, 1)));
    end
    // Watchdog, then confirm the flag is sticky across a normal transaction.
    run_txn({$urandom, $urandom}, '0, 2, 0, 2, 1'b1);
    run_txn({$urandom, $urandom}, {$urandom, $urandom}, 0, 1, 2, 1'b0);
    // Reset in RUN, then a clean transaction.
    run_txn({$urandom, $urandom}, '0, 3, 0, 0, 1'b0);
    run_txn({$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matinv_stream_ctrl.md
Name: matinv_stream_ctrl

Overview:
- Hardware initiator for the matinv<N> inverter core; drives the same start/ready/complete handshake that the inverter bench drives.
- Collects matrix elements from an input valid/ready stream and packs them into the inverter's flat matrix bus.
- Sequences the inverter through one inversion, then streams the inverse (or a singular marker) out on a valid/ready stream.
- Sits between the navigation datapath's element streams and the matinv<N> instance.

Parameters:
- DATA_WIDTH, 32: element width, fixed-point two's complement, passed through unchanged.
- MATRIX_SIZE, 3: N; matrix is N x N, NE = N*N elements.
- TIMEOUT_CYCLES, 4096: maximum RUN cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- s_valid  in  1  input element valid.
- s_ready  out  1  input element accepted when s_valid && s_ready.
- s_data  in  DATA_WIDTH  input element, row-major, element 0 first.
- m_valid  out  1  output beat valid.
- m_ready  in  1  output beat consumed when m_valid && m_ready.
- m_data  out  DATA_WIDTH  output element, row-major.
- m_last  out  1  final beat of a result.
- m_singular  out  1  result is singular or aborted; valid with m_valid.
- inv_rst  out  1  to inverter rst; 1 holds inverter idle/reset.
- inv_ready  in  1  inverter ready.
- inv_complete  in  1  inverter done.
- inv_matrix  out  NE*DATA_WIDTH  element i at [i*DATA_WIDTH +: DATA_WIDTH].
- inv_result  in  NE*DATA_WIDTH  inverse, same packing as inv_matrix.
- inv_singular  in  1  inverter singular flag.
- busy  out  1  state != LOAD.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst==0 at posedge):
  - State goes to LOAD; in/out counters = 0; m_valid = 0, m_last = 0, m_singular = 0, m_data = 0.
  - inv_rst = 1, inv_matrix = 0, err_timeout = 0.
  - Reset mid-operation aborts everything; in-flight data is discarded and no output beat is produced.
- Register rules: s_ready = (state==LOAD), combinational. inv_rst, m_* and busy are registered.
- LOAD:
  - Each accepted beat writes s_data to slot in_cnt of inv_matrix; in_cnt increments.
  - Gaps on s_valid are allowed.
  - The accept of beat NE-1 moves to WAIT_RDY and clears in_cnt.
  - inv_matrix holds stable from then until the next LOAD write.
- WAIT_RDY:
  - inv_rst stays 1.
  - The first cycle inv_ready==1 is sampled: inv_rst <= 0, move to RUN, clear the watchdog counter.
- RUN:
  - inv_complete is ignored in the first RUN cycle (stale-complete guard); it is sampled from the second cycle on.
  - On inv_complete==1:
    - Capture inv_result into the result buffer and inv_singular into sing_r.
    - inv_rst <= 1; move to DRAIN.
  - Watchdog: if TIMEOUT_CYCLES != 0 and TIMEOUT_CYCLES RUN cycles elapse without complete:
    - err_timeout <= 1, sing_r <= 1, inv_rst <= 1, move to DRAIN.
  - If complete and timeout coincide, complete wins and err_timeout is not set.
- DRAIN:
  - If sing_r: present exactly one beat: m_data = 0, m_singular = 1, m_last = 1.
  - Otherwise present NE beats: m_data = buffer[out_cnt], m_singular = 0, m_last = (out_cnt==NE-1).
  - Beat k+1 is presented in the cycle after beat k's handshake. The first beat appears in the cycle after entering DRAIN.
  - m_data, m_last and m_singular hold stable while m_valid && !m_ready.
  - The handshake of the last beat sets m_valid <= 0 and returns to LOAD. s_ready is 1 in the following cycle.
- Latency:
  - Final s-accept to inv_rst falling: 1 cycle plus inverter ready delay.
  - inv_complete to first m_valid: 2 cycles.
- Arithmetic: none; data passes bit-exact, no sign or width change.

Test Plan:
- Identity 2x2 (DATA_WIDTH=16, MATRIX_SIZE=2); stream 0x0100, 0x0000, 0x0000, 0x0100; model inverter returns its input after 10 cycles.
  -> inv_matrix = 0x0100_0000_0000_0100 (element 0 in LSBs); inv_rst falls one cycle after inv_ready; out beats 0x0100, 0, 0, 0x0100; m_last only on beat 4; m_singular = 0.
- Singular: model asserts inv_singular with complete.
  -> exactly one beat, m_data = 0, m_singular = 1, m_last = 1; then s_ready = 1.
- Backpressure: m_ready toggles 1,0,1,0 with result 0x0001..0x0004.
  -> beats 1,2,3,4 in order; m_data stable during each stall; no beat lost or duplicated.
- Input gaps: s_valid high only every third cycle.
  -> inv_matrix correct; WAIT_RDY entered exactly one cycle after the 4th accept.
- Watchdog (TIMEOUT_CYCLES=20); model never completes.
  -> after 20 RUN cycles err_timeout = 1, one singular beat, inv_rst = 1; err_timeout stays 1 until rst = 0.
- Reset mid-RUN: rst = 0 for 1 cycle.
  -> next cycle inv_rst = 1, m_valid = 0, busy = 0, s_ready = 1; a following 4-element load completes normally.
